// File: rtl/reliability_inbound_handler_pkg.sv
// Shared constants, message codes and helpers for the reliability inbound handler.
// The header-field layout is common with the outbound side and the splitter.
package reliability_inbound_handler_pkg;

  localparam int AXIS_DATA_WIDTH          = 64;
  localparam int AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8;
  localparam int AXIS_FROM_NB_TDEST_WIDTH = 8;
  localparam int AXIS_FROM_NB_TUSER_WIDTH = 16;

  localparam int PACKET_MSG_TYPE_WIDTH = 8;
  localparam int PACKET_ID_OFFSET      = 8;
  localparam int PACKET_ID_WIDTH       = 8;
  localparam int COUNT_WIDTH           = 16;

  typedef logic [PACKET_MSG_TYPE_WIDTH-1:0] msg_type_t;

  localparam msg_type_t RPM_MSG_TYPE_PUB     = 8'h01;
  localparam msg_type_t RPM_MSG_TYPE_PUBREC  = 8'h02;
  localparam msg_type_t RPM_MSG_TYPE_PUBREL  = 8'h03;
  localparam msg_type_t RPM_MSG_TYPE_PUBCOMP = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    logic [COUNT_WIDTH-1:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // A response beat carries only the message type and the echoed packet ID.
  function automatic logic [AXIS_DATA_WIDTH-1:0] build_resp_data(
    input msg_type_t                  t,
    input logic [PACKET_ID_WIDTH-1:0] id
  );
    logic [AXIS_DATA_WIDTH-1:0] d;
    d = {AXIS_DATA_WIDTH{1'b0}};
    d[PACKET_MSG_TYPE_WIDTH-1:0]                 = t;
    d[PACKET_ID_OFFSET +: PACKET_ID_WIDTH]       = id;
    return d;
  endfunction

endpackage

// File: rtl/reliability_inbound_handler_if.sv
// AXI-Stream bundle used for the inbound, to-application and response ports.
interface reliability_inbound_handler_if;
  import reliability_inbound_handler_pkg::*;

  logic                                tvalid;
  logic                                tready;
  logic [AXIS_DATA_WIDTH-1:0]          tdata;
  logic [AXIS_KEEP_WIDTH-1:0]          tkeep;
  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] tid;
  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] tdest;
  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] tuser;
  logic                                tlast;

  modport master (
    output tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
    output tready
  );

endinterface

// File: rtl/reliability_inbound_handler_id_bitmap.sv
// One-bit-per-packet-ID "already delivered" table with a combinational read port,
// plus the checker that forbids setting and clearing the same entry in one cycle.
module reliability_id_bitmap #(
  parameter int ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] rd_idx,
  output logic                rd_bit,
  input  logic                set_en,
  input  logic [ID_WIDTH-1:0] set_idx,
  input  logic                clr_en,
  input  logic [ID_WIDTH-1:0] clr_idx
);

  localparam int DEPTH = 1 << ID_WIDTH;

  logic [DEPTH-1:0] bits_r;

  assign rd_bit = bits_r[rd_idx];

  // Bitmap storage: set on first-copy PUB, clear on PUBREL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_r <= {DEPTH{1'b0}};
    end else begin
      if (set_en) begin
        bits_r[set_idx] <= 1'b1;
      end
      if (clr_en) begin
        bits_r[clr_idx] <= 1'b0;
      end
    end
  end

  reliability_id_bitmap_chk #(.ID_WIDTH(ID_WIDTH)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (set_en),
    .set_idx (set_idx),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

endmodule

module reliability_id_bitmap_chk #(
  parameter int ID_WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  input logic                set_en,
  input logic [ID_WIDTH-1:0] set_idx,
  input logic                clr_en,
  input logic [ID_WIDTH-1:0] clr_idx
);

  a_no_set_clr_same_idx: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(set_en && clr_en && (set_idx == clr_idx))
  );

endmodule

// File: rtl/reliability_inbound_handler.sv
// Receiver side of the reliability protocol: forwards first-copy PUBs to the
// application, drops duplicates, and answers PUB/PUBREL with PUBREC/PUBCOMP.
module reliability_inbound_handler
  import reliability_inbound_handler_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_ap_rst_n,
  reliability_inbound_handler_if.slave  in_axis,
  reliability_inbound_handler_if.master to_app_axis,
  reliability_inbound_handler_if.master resp_axis,
  output logic [COUNT_WIDTH-1:0]       o_dup_count,
  output logic [COUNT_WIDTH-1:0]       o_bad_type_count
);

  state_t                              state_r;
  state_t                              state_s;
  msg_type_t                           first_type_s;
  logic [PACKET_ID_WIDTH-1:0]          first_id_s;
  logic                                is_pub_s;
  logic                                is_pubrel_s;
  logic                                seen_s;
  logic                                in_ready_s;
  logic                                app_valid_s;
  logic                                resp_valid_s;
  logic                                in_hs_s;
  logic                                first_hs_s;
  logic                                set_en_s;
  logic                                clr_en_s;
  logic                                dup_hit_s;
  logic                                bad_hit_s;
  logic [AXIS_DATA_WIDTH-1:0]          resp_data_r;
  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] resp_tid_r;
  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] resp_tdest_r;
  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] resp_user_r;
  logic                                bad_r;
  logic [COUNT_WIDTH-1:0]              dup_count_r;
  logic [COUNT_WIDTH-1:0]              bad_count_r;

  assign first_type_s = in_axis.tdata[PACKET_MSG_TYPE_WIDTH-1:0];
  assign first_id_s   = in_axis.tdata[PACKET_ID_OFFSET +: PACKET_ID_WIDTH];
  assign is_pub_s     = (first_type_s == RPM_MSG_TYPE_PUB);
  assign is_pubrel_s  = (first_type_s == RPM_MSG_TYPE_PUBREL);

  assign in_hs_s    = in_axis.tvalid && in_ready_s;
  assign first_hs_s = (state_r == ST_IDLE) && in_hs_s;
  assign set_en_s   = first_hs_s && is_pub_s && !seen_s;
  assign clr_en_s   = first_hs_s && is_pubrel_s;
  assign dup_hit_s  = first_hs_s && is_pub_s && seen_s;
  assign bad_hit_s  = first_hs_s && !is_pub_s && !is_pubrel_s;

  reliability_id_bitmap #(.ID_WIDTH(PACKET_ID_WIDTH)) u_bitmap (
    .clk     (i_clk),
    .rst_n   (i_ap_rst_n),
    .rd_idx  (first_id_s),
    .rd_bit  (seen_s),
    .set_en  (set_en_s),
    .set_idx (first_id_s),
    .clr_en  (clr_en_s),
    .clr_idx (first_id_s)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; only IDLE interprets a first beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_hs_s) begin
          if (is_pub_s && !seen_s) begin
            state_s = in_axis.tlast ? ST_RESP : ST_FWD;
          end else if (is_pub_s || is_pubrel_s) begin
            state_s = in_axis.tlast ? ST_RESP : ST_DROP;
          end else begin
            state_s = in_axis.tlast ? ST_IDLE : ST_DROP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (in_hs_s && in_axis.tlast) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_FWD;
        end
      end
      ST_DROP: begin
        if (in_hs_s && in_axis.tlast) begin
          state_s = bad_r ? ST_IDLE : ST_RESP;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_RESP: begin
        if (resp_axis.tready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs; held inactive while reset is asserted so a half-received
  // beat is not misread as a first beat before the clock resumes.
  always_comb begin
    in_ready_s   = 1'b0;
    app_valid_s  = 1'b0;
    resp_valid_s = 1'b0;
    if (!i_ap_rst_n) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_axis.tvalid && is_pub_s && !seen_s) begin
            in_ready_s  = to_app_axis.tready;
            app_valid_s = 1'b1;
          end else if (in_axis.tvalid) begin
            in_ready_s = 1'b1;
          end else begin
            in_ready_s = 1'b0;
          end
        end
        ST_FWD: begin
          in_ready_s  = to_app_axis.tready;
          app_valid_s = in_axis.tvalid;
        end
        ST_DROP: begin
          in_ready_s = 1'b1;
        end
        ST_RESP: begin
          resp_valid_s = 1'b1;
        end
        default: begin
          in_ready_s = 1'b0;
        end
      endcase
    end
  end

  // Response context captured at the first-beat handshake; tid/tdest swap so the
  // reply is addressed back to the sender.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      resp_data_r  <= {AXIS_DATA_WIDTH{1'b0}};
      resp_tid_r   <= {AXIS_FROM_NB_TDEST_WIDTH{1'b0}};
      resp_tdest_r <= {AXIS_FROM_NB_TDEST_WIDTH{1'b0}};
      resp_user_r  <= {AXIS_FROM_NB_TUSER_WIDTH{1'b0}};
      bad_r        <= 1'b0;
    end else if (first_hs_s) begin
      resp_data_r  <= build_resp_data(is_pub_s ? RPM_MSG_TYPE_PUBREC : RPM_MSG_TYPE_PUBCOMP,
                                      first_id_s);
      resp_tid_r   <= in_axis.tdest;
      resp_tdest_r <= in_axis.tid;
      resp_user_r  <= in_axis.tuser;
      bad_r        <= bad_hit_s;
    end
  end

  // Saturating event counters.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      dup_count_r <= 16'd0;
      bad_count_r <= 16'd0;
    end else begin
      if (dup_hit_s) begin
        dup_count_r <= sat_inc(dup_count_r);
      end
      if (bad_hit_s) begin
        bad_count_r <= sat_inc(bad_count_r);
      end
    end
  end

  assign in_axis.tready     = in_ready_s;

  assign to_app_axis.tvalid = app_valid_s;
  assign to_app_axis.tdata  = in_axis.tdata;
  assign to_app_axis.tkeep  = in_axis.tkeep;
  assign to_app_axis.tid    = in_axis.tid;
  assign to_app_axis.tdest  = in_axis.tdest;
  assign to_app_axis.tuser  = in_axis.tuser;
  assign to_app_axis.tlast  = in_axis.tlast;

  assign resp_axis.tvalid   = resp_valid_s;
  assign resp_axis.tdata    = resp_data_r;
  assign resp_axis.tkeep    = {AXIS_KEEP_WIDTH{1'b1}};
  assign resp_axis.tid      = resp_tid_r;
  assign resp_axis.tdest    = resp_tdest_r;
  assign resp_axis.tuser    = resp_user_r;
  assign resp_axis.tlast    = 1'b1;

  assign o_dup_count        = dup_count_r;
  assign o_bad_type_count   = bad_count_r;

endmodule

// File: tb/tb_reliability_inbound_handler.sv
// Randomized scoreboard bench for reliability_inbound_handler with an
// exactly-once reference model kept as a plain per-ID array.
module tb_reliability_inbound_handler;
  import reliability_inbound_handler_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  tid;
    logic [7:0]  tdest;
    logic [15:0] user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dup_count;
  logic [15:0] bad_count;

  reliability_inbound_handler_if in_axis();
  reliability_inbound_handler_if to_app_axis();
  reliability_inbound_handler_if resp_axis();

  reliability_inbound_handler dut (
    .i_clk            (clk),
    .i_ap_rst_n       (rst_n),
    .in_axis          (in_axis),
    .to_app_axis      (to_app_axis),
    .resp_axis        (resp_axis),
    .o_dup_count      (dup_count),
    .o_bad_type_count (bad_count)
  );

  always #5 clk = ~clk;

  beat_t exp_app[$];
  beat_t exp_resp[$];
  bit    ref_bm[256];
  int    ref_dup;
  int    ref_bad;
  int    n_chk;
  int    n_fail;
  int    mode;
  int    rwait;
  bit    pend_chk;
  bit    cur_resp;
  beat_t mon_e;
  beat_t mon_a;

  function automatic logic [127:0] pack_beat(input beat_t b);
    return {23'd0, b.data, b.keep, b.tid, b.tdest, b.user, b.last};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Sink ready patterns: 0 always ready, 1 toggle app / stall resp 5 cycles, 2 random.
  always @(posedge clk) begin
    #1;
    rwait = resp_axis.tvalid ? rwait + 1 : 0;
    case (mode)
      1: begin
        to_app_axis.tready = ~to_app_axis.tready;
        resp_axis.tready   = (rwait > 5);
      end
      2: begin
        to_app_axis.tready = ($urandom_range(0, 3) != 0);
        resp_axis.tready   = $urandom_range(0, 1);
      end
      default: begin
        to_app_axis.tready = 1'b1;
        resp_axis.tready   = 1'b1;
      end
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_chk) begin
        chk("resp_latency", resp_axis.tvalid, 1'b1);
        pend_chk = 1'b0;
      end
      if (resp_axis.tvalid) chk("in_tready_in_resp", in_axis.tready, 1'b0);
      if (in_axis.tvalid && in_axis.tready && in_axis.tlast && cur_resp) pend_chk = 1'b1;
      if (to_app_axis.tvalid && to_app_axis.tready) begin
        mon_a = '{to_app_axis.tdata, to_app_axis.tkeep, to_app_axis.tid,
                  to_app_axis.tdest, to_app_axis.tuser, to_app_axis.tlast};
        n_chk++;
        if (exp_app.size() == 0) begin
          n_fail++;
          $display("FAIL app_unexpected: actual beat %0h, required none", pack_beat(mon_a));
        end else begin
          n_chk--;
          mon_e = exp_app.pop_front();
          chk("app_beat", pack_beat(mon_a), pack_beat(mon_e));
        end
      end
      if (resp_axis.tvalid && resp_axis.tready) begin
        mon_a = '{resp_axis.tdata, resp_axis.tkeep, resp_axis.tid,
                  resp_axis.tdest, resp_axis.tuser, resp_axis.tlast};
        n_chk++;
        if (exp_resp.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: actual beat %0h, required none", pack_beat(mon_a));
        end else begin
          n_chk--;
          mon_e = exp_resp.pop_front();
          chk("resp_beat", pack_beat(mon_a), pack_beat(mon_e));
        end
      end
    end
  end

  task automatic send_pkt(input logic [7:0] t, input logic [7:0] pid, input int nb);
    beat_t       b[$];
    beat_t       x;
    beat_t       r;
    logic [7:0]  tid_v;
    logic [7:0]  dest_v;
    int          w;
    tid_v  = 8'($urandom);
    dest_v = 8'($urandom);
    for (int i = 0; i < nb; i++) begin
      x.data = {$urandom, $urandom};
      if (i == 0) begin
        x.data[7:0]  = t;
        x.data[15:8] = pid;
      end
      x.keep  = 8'($urandom);
      x.tid   = tid_v;
      x.tdest = dest_v;
      x.user  = 16'($urandom);
      x.last  = (i == nb - 1);
      b.push_back(x);
    end
    // Reference: deliver once per ID until released; reply to the sender.
    r = '{64'd0, 8'hFF, dest_v, tid_v, b[0].user, 1'b1};
    cur_resp = 1'b1;
    if (t == RPM_MSG_TYPE_PUB) begin
      if (!ref_bm[pid]) begin
        foreach (b[i]) exp_app.push_back(b[i]);
        ref_bm[pid] = 1'b1;
      end else begin
        ref_dup++;
      end
      r.data = {48'd0, pid, 8'h02};
      exp_resp.push_back(r);
    end else if (t == RPM_MSG_TYPE_PUBREL) begin
      ref_bm[pid] = 1'b0;
      r.data = {48'd0, pid, 8'h04};
      exp_resp.push_back(r);
    end else begin
      ref_bad++;
      cur_resp = 1'b0;
    end
    for (int i = 0; i < nb; i++) begin
      @(posedge clk);
      #1;
      in_axis.tvalid = 1'b1;
      in_axis.tdata  = b[i].data;
      in_axis.tkeep  = b[i].keep;
      in_axis.tid    = b[i].tid;
      in_axis.tdest  = b[i].tdest;
      in_axis.tuser  = b[i].user;
      in_axis.tlast  = b[i].last;
      w = 0;
      @(negedge clk);
      while (!in_axis.tready && w < 300) begin
        w++;
        @(negedge clk);
      end
      if (!in_axis.tready) begin
        n_chk++;
        n_fail++;
        $display("FAIL in_handshake_timeout: actual tready=0 after %0d cycles, required 1", w);
      end
    end
    @(posedge clk);
    #1;
    in_axis.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_app.size() != 0 || exp_resp.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: actual app=%0d resp=%0d pending, required 0",
               exp_app.size(), exp_resp.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    beat_t      rb;
    logic [7:0] t;
    rst_n = 1'b0;
    in_axis.tvalid = 1'b0;
    in_axis.tdata  = 64'd0;
    in_axis.tkeep  = 8'd0;
    in_axis.tid    = 8'd0;
    in_axis.tdest  = 8'd0;
    in_axis.tuser  = 16'd0;
    in_axis.tlast  = 1'b0;
    to_app_axis.tready = 1'b1;
    resp_axis.tready   = 1'b1;
    mode = 0; rwait = 0; pend_chk = 1'b0; cur_resp = 1'b0;
    ref_dup = 0; ref_bad = 0; n_chk = 0; n_fail = 0;
    foreach (ref_bm[i]) ref_bm[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_app_tvalid", to_app_axis.tvalid, 1'b0);
    chk("rst_resp_tvalid", resp_axis.tvalid, 1'b0);
    chk("rst_in_tready", in_axis.tready, 1'b0);
    chk("rst_dup_count", dup_count, 16'd0);
    chk("rst_bad_count", bad_count, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_tready", in_axis.tready, 1'b0);

    send_pkt(RPM_MSG_TYPE_PUB, 8'h05, 3);
    wait_drain();
    send_pkt(RPM_MSG_TYPE_PUB, 8'h05, 2);
    wait_drain();
    chk("dup_after_repeat", dup_count, 16'd1);
    send_pkt(RPM_MSG_TYPE_PUBREL, 8'h05, 1);
    send_pkt(RPM_MSG_TYPE_PUB, 8'h05, 1);
    wait_drain();
    send_pkt(RPM_MSG_TYPE_PUBREC, 8'h05, 2);
    wait_drain();
    chk("bad_after_pubrec", bad_count, 16'd1);

    mode = 1;
    send_pkt(RPM_MSG_TYPE_PUB, 8'h09, 4);
    send_pkt(RPM_MSG_TYPE_PUB, 8'h09, 3);
    wait_drain();
    mode = 2;
    repeat (60) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: t = RPM_MSG_TYPE_PUB;
        6, 7:             t = RPM_MSG_TYPE_PUBREL;
        8:                t = RPM_MSG_TYPE_PUBCOMP;
        default:          t = 8'($urandom_range(16, 255));
      endcase
      send_pkt(t, 8'($urandom_range(0, 7)), $urandom_range(1, 4));
    end
    wait_drain();
    mode = 0;
    repeat (2) @(negedge clk);
    chk("dup_count_random", dup_count, 16'(ref_dup));
    chk("bad_count_random", bad_count, 16'(ref_bad));

    // Reset during beat 2 of a forwarded PUB id 0xFF.
    rb = '{{$urandom, $urandom}, 8'hFF, 8'h11, 8'h22, 16'h3344, 1'b0};
    rb.data[15:0] = {8'hFF, RPM_MSG_TYPE_PUB};
    exp_app.push_back(rb);
    cur_resp = 1'b1;
    @(posedge clk);
    #1;
    in_axis.tvalid = 1'b1;
    in_axis.tdata  = rb.data;
    in_axis.tkeep  = rb.keep;
    in_axis.tid    = rb.tid;
    in_axis.tdest  = rb.tdest;
    in_axis.tuser  = rb.user;
    in_axis.tlast  = 1'b0;
    @(negedge clk);
    chk("rst_pkt_first_ready", in_axis.tready, 1'b1);
    @(posedge clk);
    #1;
    in_axis.tdata = {$urandom, $urandom};
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_app_tvalid", to_app_axis.tvalid, 1'b0);
    chk("midrst_resp_tvalid", resp_axis.tvalid, 1'b0);
    chk("midrst_in_tready", in_axis.tready, 1'b0);
    chk("midrst_first_beat_fwd", exp_app.size(), 0);
    in_axis.tvalid = 1'b0;
    exp_app.delete();
    exp_resp.delete();
    pend_chk = 1'b0;
    foreach (ref_bm[i]) ref_bm[i] = 1'b0;
    ref_dup = 0;
    ref_bad = 0;
    chk("midrst_dup_count", dup_count, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("postrst_no_resp", resp_axis.tvalid, 1'b0);
    send_pkt(RPM_MSG_TYPE_PUB, 8'hFF, 2);
    wait_drain();
    chk("postrst_dup_count", dup_count, 16'd0);
    chk("final_app_queue", exp_app.size(), 0);
    chk("final_resp_queue", exp_resp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reliability_inbound_handler.md
# reliability_inbound_handler

Receiver half of the control-API reliability protocol. Consumes the PUB/PUBREL stream produced by the from-network-bridge splitter's inbound port and forwards first-copy PUB packets to the application. It drops duplicate PUBs and answers every PUB with PUBREC and every PUBREL with PUBCOMP on a single-beat response stream toward the network bridge. A per-packet-ID bitmap implements exactly-once delivery.

## Interface
- AXIS_DATA_WIDTH, 64, data width of all AXIS ports (shared header)
- AXIS_KEEP_WIDTH, 8, AXIS_DATA_WIDTH/8
- AXIS_FROM_NB_TDEST_WIDTH, 8, tid/tdest width
- AXIS_FROM_NB_TUSER_WIDTH, 16, tuser width
- PACKET_ID_WIDTH, 8, packet-ID field width; bitmap has 2^PACKET_ID_WIDTH entries
- i_clk  in  1  sole clock
- i_ap_rst_n  in  1  asynchronous, active-low reset
- in_tvalid/in_tready/in_tdata/in_tkeep/in_tid/in_tdest/in_tuser/in_tlast  in (tready out)  AXIS widths above  stream from splitter inbound port
- to_app_t*  out (tready in)  same set  forwarded PUB packets, beats unchanged
- resp_t*  out (tready in)  same set  PUBREC/PUBCOMP beats toward network bridge
- o_dup_count  out  16  duplicate PUBs dropped, saturating
- o_bad_type_count  out  16  packets with a type other than PUB/PUBREL, saturating

## Operation
- First beat of each packet: msg type is tdata[PACKET_MSG_TYPE_WIDTH-1:0]; ID is tdata[PACKET_ID_OFFSET +: PACKET_ID_WIDTH].
- The FSM has states IDLE, FWD, DROP, RESP. IDLE is the only state that decodes a first beat.
- IDLE, PUB, bitmap[id]==0:
  - in_tready = to_app_tready; to_app_tvalid = in_tvalid.
  - On handshake: set bitmap[id], latch id/tid/tdest/tuser, pending response = PUBREC.
  - Next state: FWD, or RESP if tlast.
- IDLE, PUB, bitmap[id]==1:
  - in_tready=1; nothing to app.
  - Increment o_dup_count; pending response = PUBREC.
  - Next state: DROP, or RESP if tlast.
- IDLE, PUBREL:
  - in_tready=1.
  - On handshake: clear bitmap[id] (no-op if already clear); pending response = PUBCOMP.
  - Next state: DROP, or RESP if tlast.
- IDLE, other type: in_tready=1; increment o_bad_type_count; no response; DROP, or stay IDLE if tlast.
- FWD: in_tready = to_app_tready; beats pass through combinationally; on tlast handshake go to RESP.
- DROP: in_tready=1; on tlast handshake go to RESP, or to IDLE for a bad-type packet.
- RESP: resp_tvalid=1 with:
  - tdata all zero except msg type field = pending type and ID field = latched id.
  - tkeep all ones; tlast=1; tuser latched.
  - tdest = latched in_tid and tid = latched in_tdest, so the reply is addressed to the sender.
  - On resp_tready go to IDLE. in_tready=0 while in RESP.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: all tvalid 0, in_tready 0, counters 0, bitmap all zero, state IDLE.
- Data path latency is 0 cycles: app data is combinational from the input in IDLE/FWD, with no output register.
- Response is valid in the cycle after the input tlast handshake. The earliest next first beat is accepted in the cycle after the resp handshake.
- Throughput: one packet per (beats + 1 + response-stall) cycles.
- The bitmap is read combinationally on the IDLE first beat and written at that handshake. A PUB and a PUBREL for the same id can never be decoded in the same cycle.
- A tvalid-high, tready-low hold on any port must keep all outputs stable (AXIS rules). to_app_tvalid never depends on to_app_tready.
- Asynchronous reset mid-packet truncates any app packet in flight (no tlast emitted), clears the bitmap, and discards any pending response. Post-reset, the remainder of the interrupted input packet is decoded as a new first beat.

## Structure
- Add PACKET_ID_OFFSET and PACKET_ID_WIDTH alongside the RPM_MSG_TYPE_* codes in ctrl_api_reliability_message_parameters.vh, shared with the outbound side and the splitter. Add a state enum typedef there too.
- Natural sub-module: reliability_id_bitmap.
  - Contents: 2^PACKET_ID_WIDTH flops.
  - Ports: combinational read port, set port, clear port, async clear on reset.
  - Rule: set and clear of the same index in one cycle is illegal, enforced by an assertion.
- Response formatter and counters stay in the top module.

## Test plan
- PUB id 0x05, 3 beats, all treadies high → 3 identical beats on to_app with tlast on beat 3. Next cycle: resp beat with type PUBREC, id 0x05, tdest = input tid. bitmap[5]=1.
- Same PUB id 0x05 repeated → nothing on to_app; PUBREC id 0x05 emitted; o_dup_count=1.
- PUBREL id 0x05 (1 beat) → PUBCOMP id 0x05; bitmap[5]=0. A following PUB id 0x05 is forwarded again.
- Type PUBREC (illegal here), 2 beats → both beats consumed, no output on either port, o_bad_type_count=1.
- to_app_tready toggles 1/0 per cycle during a 4-beat PUB, and resp_tready is held low 5 cycles → no beat lost or duplicated; in_tready=0 throughout RESP.
- Assert reset while in beat 2 of a PUB id 0xFF → all tvalids 0 on the same cycle, bitmap[0xFF]=0, no response after reset release.
